// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and round-robin pick function for the 4-way arbiter
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [1:0] req_idx_t;

  // Scan last_ptr+1 .. last_ptr+4 (mod 4) and return the first requester found.
  // Scanning from the far end lets the nearest set bit overwrite the others.
  // With no request set, last_ptr comes back; the caller only uses it when req != 0.
  function automatic req_idx_t rr_pick(input logic [3:0] req, input req_idx_t last_ptr);
    req_idx_t idx;
    rr_pick = last_ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = last_ptr + req_idx_t'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arb_4_pol_grant_dec.sv
// rtl/rr_arb_4_pol_grant_dec.sv - 2-to-4 decoder with enable and output polarity
module dec_2_to_4_en_pol (
  input  logic A1,
  input  logic A0,
  input  logic EN,
  input  logic POL,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0
);

  logic [1:0] sel;

  assign sel = {A1, A0};

  // A line is active only when enabled and selected; POL flips every line to active-low.
  assign Y0 = (EN & (sel == 2'd0)) ^ POL;
  assign Y1 = (EN & (sel == 2'd1)) ^ POL;
  assign Y2 = (EN & (sel == 2'd2)) ^ POL;
  assign Y3 = (EN & (sel == 2'd3)) ^ POL;

endmodule

// File: rtl/rr_arb_4_pol_grant.sv
// rtl/rr_arb_4_pol_grant.sv - four-requester round-robin arbiter with hold timeout and grant polarity
module rr_arb_4_pol_grant
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 15,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic [3:0] grant_o,
  output logic [1:0] owner_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  // With no timeout the counter just parks at all-ones; it has no visible effect.
  localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HOLD_MAX;

  arb_state_t    state_q;
  req_idx_t      owner_q;
  req_idx_t      last_q;
  logic [HW-1:0] hold_q;
  logic          timeout_q;

  req_idx_t      pick_d;
  logic          rel_end_d;
  logic          exp_end_d;
  logic [HW-1:0] hold_d;

  // Next owner candidate, ownership-end conditions and the saturating hold increment.
  always_comb begin
    pick_d    = rr_pick(req_i, last_q);
    rel_end_d = release_i | ~req_i[owner_q];
    exp_end_d = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
    hold_d    = (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);
  end

  // Arbitration FSM: owner selection, pointer update, hold counting and timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE) begin
      timeout_q <= 1'b0;
      if (|req_i) begin
        state_q <= GRANT;
        owner_q <= pick_d;
        hold_q  <= HW'(1);
      end
    end else begin
      if (rel_end_d | exp_end_d) begin
        // Always drop back to IDLE so consecutive grants are separated by one idle cycle.
        state_q   <= IDLE;
        last_q    <= owner_q;
        hold_q    <= '0;
        timeout_q <= exp_end_d & ~rel_end_d;
      end else begin
        timeout_q <= 1'b0;
        hold_q    <= hold_d;
      end
    end
  end

  assign busy_o    = (state_q == GRANT);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

  dec_2_to_4_en_pol u_dec (
    .A1  (owner_q[1]),
    .A0  (owner_q[0]),
    .EN  (state_q == GRANT),
    .POL (ACTIVE_LOW),
    .Y3  (grant_o[3]),
    .Y2  (grant_o[2]),
    .Y1  (grant_o[1]),
    .Y0  (grant_o[0])
  );

endmodule

// File: tb/tb_rr_arb_4_pol_grant.sv
// tb/tb_rr_arb_4_pol_grant.sv - self-checking bench for rr_arb_4_pol_grant
module tb_rr_arb_4_pol_grant;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;

  logic [3:0] g0, g1;
  logic [1:0] o0, o1;
  logic       b0, b1, t0, t1;

  always #5 clk = ~clk;

  rr_arb_4_pol_grant #(.MAX_HOLD(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
    .grant_o(g0), .owner_o(o0), .busy_o(b0), .timeout_o(t0)
  );

  rr_arb_4_pol_grant #(.MAX_HOLD(0), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .release_i(rel),
    .grant_o(g1), .owner_o(o1), .busy_o(b1), .timeout_o(t1)
  );

  int tests = 0;
  int fails = 0;

  int mh[2] = '{4, 0};
  int al[2] = '{0, 1};
  int m_busy[2];
  int m_own[2];
  int m_last[2];
  int m_hold[2];
  int m_to[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: advance one clock using the inputs seen at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_own[i] = 0; m_last[i] = 3; m_hold[i] = 0; m_to[i] = 0;
      end else if (m_busy[i] == 0) begin
        m_to[i] = 0;
        if (req != 4'b0000) begin
          for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last[i] + k) % 4;
            if (req[c] && m_busy[i] == 0) begin
              m_own[i]  = c;
              m_busy[i] = 1;
              m_hold[i] = 1;
            end
          end
        end
      end else begin
        bit by_rel, by_drop, by_exp;
        by_rel  = (rel == 1'b1);
        by_drop = (req[m_own[i]] == 1'b0);
        by_exp  = (mh[i] != 0) && (m_hold[i] >= mh[i]);
        if (by_rel || by_drop || by_exp) begin
          m_busy[i] = 0;
          m_last[i] = m_own[i];
          m_hold[i] = 0;
          m_to[i]   = (by_exp && !by_rel && !by_drop) ? 1 : 0;
        end else begin
          m_to[i] = 0;
          m_hold[i]++;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_grant(input int i);
    logic [3:0] g;
    for (int k = 0; k < 4; k++)
      g[k] = ((m_busy[i] != 0) && (m_own[i] == k)) ^ (al[i] != 0);
    return g;
  endfunction

  task automatic check_all();
    check("u0_grant",   32'(g0), 32'(exp_grant(0)));
    check("u0_owner",   32'(o0), 32'(m_own[0]));
    check("u0_busy",    32'(b0), 32'(m_busy[0]));
    check("u0_timeout", 32'(t0), 32'(m_to[0]));
    check("u1_grant",   32'(g1), 32'(exp_grant(1)));
    check("u1_owner",   32'(o1), 32'(m_own[1]));
    check("u1_busy",    32'(b1), 32'(m_busy[1]));
    check("u1_timeout", 32'(t1), 32'(m_to[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  logic [3:0] rot_seq [8];

  initial begin
    rot_seq = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    // Reset with everything requesting, then first grant goes to requester 0.
    rst_n = 1'b0; req = 4'b1111; rel = 1'b0;
    tick(); tick();
    check("rst_grant", 32'(g0), 32'h0);
    check("rst_busy", 32'(b0), 32'h0);
    check("rst_grant_al", 32'(g1), 32'hf);
    rst_n = 1'b1;
    tick();
    check("first_grant", 32'(g0), 32'h1);
    check("first_owner", 32'(o0), 32'h0);

    // Rotation with release every grant cycle.
    rel = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      check($sformatf("rot_%0d", n), 32'(g0), 32'(rot_seq[n]));
    end

    // Hold timeout on a single requester.
    rst_n = 1'b0; rel = 1'b0; req = 4'b0100;
    tick();
    rst_n = 1'b1;
    tick();
    check("al_grant2", 32'(g1), 32'hb);
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("hold_%0d", n), 32'(g0), 32'h4);
      check($sformatf("hold_to_%0d", n), 32'(t0), 32'h0);
    end
    tick();
    check("to_gap_grant", 32'(g0), 32'h0);
    check("to_pulse", 32'(t0), 32'h1);
    tick();
    check("to_regrant", 32'(g0), 32'h4);
    check("to_pulse_end", 32'(t0), 32'h0);

    // Release on the last permitted cycle wins over expiry.
    tick(); tick(); tick();
    rel = 1'b1;
    tick();
    check("rel_no_to", 32'(t0), 32'h0);
    check("rel_gap", 32'(g0), 32'h0);
    rel = 1'b0;
    tick(); tick();
    req = 4'b0000;
    tick();
    check("drop_grant", 32'(g0), 32'h0);

    // Reset in the middle of a grant.
    req = 4'b0100;
    tick();
    check("pre_mid_rst", 32'(o0), 32'h2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_grant", 32'(g0), 32'h0);
    check("mid_rst_to", 32'(t0), 32'h0);
    rst_n = 1'b1; req = 4'b0101;
    tick();
    check("post_rst_owner", 32'(o0), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < 4; k++) req[k] = ($urandom_range(0, 9) < 7);
      rel = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
